// File: rtl/keygen_fg_sequencer.sv
// Runs the small-polynomial generator for f then g, streams both to key RAM and
// restarts the pair whenever ||f||^2 + ||g||^2 reaches the norm bound.
module keygen_fg_sequencer #(
   parameter int unsigned logn       = 9,
   parameter int unsigned NORM_BOUND = 16823,
   parameter int unsigned ACC_W      = 2 * 8 + logn + 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   output logic                      busy,
   output logic                      gen_ena,
   input  logic                      gen_f_valid,
   input  logic [8*(1 << logn)-1:0]  gen_f,
   output logic                      wr_en,
   output logic                      wr_sel,
   output logic [logn-1:0]           wr_addr,
   output logic [7:0]                wr_data,
   output logic                      done,
   output logic [15:0]               attempts
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] GEN_F  = 3'd1;
   localparam logic [2:0] COPY_F = 3'd2;
   localparam logic [2:0] GEN_G  = 3'd3;
   localparam logic [2:0] COPY_G = 3'd4;
   localparam logic [2:0] CHECK  = 3'd5;
   localparam logic [2:0] DONE   = 3'd6;

   localparam logic [ACC_W-1:0] BOUND = ACC_W'(NORM_BOUND);

   logic [2:0]       state_q, state_d;
   logic [logn-1:0]  idx_q, idx_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [15:0]      attempts_q, attempts_d;
   logic [7:0]       wr_data_q, wr_data_d;
   logic             busy_q, busy_d;
   logic             gen_ena_q, gen_ena_d;
   logic             wr_en_q, wr_en_d;
   logic             wr_sel_q, wr_sel_d;
   logic             done_q, done_d;

   // Square of the coefficient currently on the write port; fits 16 bits even for -128.
   logic signed [15:0] data_sx;
   logic        [15:0] data_sq;

   assign data_sx = {{8{wr_data_q[7]}}, wr_data_q};
   assign data_sq = 16'(data_sx * data_sx);

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      acc_d      = acc_q;
      attempts_d = attempts_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = GEN_F;
               idx_d      = '0;
               acc_d      = '0;
               attempts_d = '0;
            end
         end
         GEN_F: begin
            if (gen_f_valid) begin
               state_d = COPY_F;
               idx_d   = '0;
            end
         end
         GEN_G: begin
            if (gen_f_valid) begin
               state_d = COPY_G;
               idx_d   = '0;
            end
         end
         COPY_F, COPY_G: begin
            acc_d = acc_q + ACC_W'(data_sq);
            // idx wraps to zero naturally after n-1
            idx_d = idx_q + logn'(1);
            if (&idx_q) begin
               state_d = (state_q == COPY_F) ? GEN_G : CHECK;
            end
         end
         CHECK: begin
            if (acc_q >= BOUND) begin
               state_d    = GEN_F;
               acc_d      = '0;
               attempts_d = (attempts_q == 16'hFFFF) ? attempts_q : attempts_q + 16'd1;
            end else begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs are registered from the next state so they line up with it.
   always_comb begin
      busy_d    = (state_d != IDLE) && (state_d != DONE);
      gen_ena_d = (state_d == GEN_F) || (state_d == GEN_G);
      wr_en_d   = (state_d == COPY_F) || (state_d == COPY_G);
      wr_sel_d  = (state_d == COPY_G);
      done_d    = (state_d == DONE);
      wr_data_d = wr_data_q;
      if (wr_en_d) begin
         wr_data_d = gen_f[{idx_d, 3'b000} +: 8];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         acc_q      <= '0;
         attempts_q <= '0;
         wr_data_q  <= '0;
         busy_q     <= 1'b0;
         gen_ena_q  <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_sel_q   <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         acc_q      <= acc_d;
         attempts_q <= attempts_d;
         wr_data_q  <= wr_data_d;
         busy_q     <= busy_d;
         gen_ena_q  <= gen_ena_d;
         wr_en_q    <= wr_en_d;
         wr_sel_q   <= wr_sel_d;
         done_q     <= done_d;
      end
   end

   assign busy     = busy_q;
   assign gen_ena  = gen_ena_q;
   assign wr_en    = wr_en_q;
   assign wr_sel   = wr_sel_q;
   assign wr_addr  = idx_q;
   assign wr_data  = wr_data_q;
   assign done     = done_q;
   assign attempts = attempts_q;

endmodule

// File: tb/tb_keygen_fg_sequencer.sv
// Directed bench for keygen_fg_sequencer: a model generator pushes expected RAM writes
// to a queue that a monitor pops and compares as the DUT streams them out.
`timescale 1ns/1ps
module tb_keygen_fg_sequencer;

   localparam int unsigned LOGN = 2;
   localparam int          N    = 4;

   localparam logic [31:0] F1   = 32'h0003FE01;  // {1,-2,3,0}
   localparam logic [31:0] G1   = 32'hFF010100;  // {0,1,1,-1}
   localparam logic [31:0] FBIG = 32'h0000807F;  // {127,-128,0,0}

   typedef struct packed {
      logic       sel;
      logic [1:0] addr;
      logic [7:0] data;
   } wr_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, start, gen_f_valid;
   logic [31:0] gen_f;
   logic        busy, gen_ena, wr_en, wr_sel, done;
   logic [1:0]  wr_addr;
   logic [7:0]  wr_data;
   logic [15:0] attempts;

   logic        rst_n_s, start_s, gen_f_valid_s;
   logic [31:0] gen_f_s;
   logic        busy_s, gen_ena_s, wr_en_s, wr_sel_s, done_s;
   logic [1:0]  wr_addr_s;
   logic [7:0]  wr_data_s;
   logic [15:0] attempts_s;

   // Rejection-only instance: its generator answers in the first GEN cycle.
   assign gen_f_valid_s = gen_ena_s;
   assign gen_f_s       = '0;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int dones  = 0;
   int dones_s = 0;
   wr_t exp_q[$];

   keygen_fg_sequencer #(.logn(LOGN), .NORM_BOUND(16823)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .gen_ena(gen_ena),
      .gen_f_valid(gen_f_valid), .gen_f(gen_f), .wr_en(wr_en), .wr_sel(wr_sel),
      .wr_addr(wr_addr), .wr_data(wr_data), .done(done), .attempts(attempts)
   );

   keygen_fg_sequencer #(.logn(LOGN), .NORM_BOUND(0)) dut_s (
      .clk(clk), .rst_n(rst_n_s), .start(start_s), .busy(busy_s), .gen_ena(gen_ena_s),
      .gen_f_valid(gen_f_valid_s), .gen_f(gen_f_s), .wr_en(wr_en_s), .wr_sel(wr_sel_s),
      .wr_addr(wr_addr_s), .wr_data(wr_data_s), .done(done_s), .attempts(attempts_s)
   );

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   always @(negedge clk) begin
      wr_t e;
      if (done) dones++;
      if (done_s) dones_s++;
      if (wr_en) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL wr_unexpected: observed write sel=%0d addr=%0d, expected none",
                   wr_sel, wr_addr);
         end else begin
            e = exp_q.pop_front();
            check("wr_sel", {31'd0, wr_sel}, {31'd0, e.sel});
            check("wr_addr", {30'd0, wr_addr}, {30'd0, e.addr});
            check("wr_data", {24'd0, wr_data}, {24'd0, e.data});
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, {31'd0, busy}, 0);
      check({tag, "_gen_ena"}, {31'd0, gen_ena}, 0);
      check({tag, "_wr_en"}, {31'd0, wr_en}, 0);
      check({tag, "_wr_sel"}, {31'd0, wr_sel}, 0);
      check({tag, "_wr_addr"}, {30'd0, wr_addr}, 0);
      check({tag, "_wr_data"}, {24'd0, wr_data}, 0);
      check({tag, "_done"}, {31'd0, done}, 0);
      check({tag, "_attempts"}, {16'd0, attempts}, 0);
   endtask

   task automatic start_pulse(output int s);
      s = cyc;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_busy", {31'd0, busy}, 1);
      check("start_gen_ena", {31'd0, gen_ena}, 1);
   endtask

   // Model generator: waits for gen_ena, answers after lat cycles, queues expected writes.
   task automatic gen_run(input logic sel, input logic [31:0] coefs, input int lat,
                          output int rise_cyc, output int pulse_cyc);
      int t;
      t = 0;
      while (gen_ena !== 1'b1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      rise_cyc = cyc;
      check("gen_ena_wait", {31'd0, gen_ena}, 1);
      repeat (lat) @(negedge clk);
      gen_f       = coefs;
      gen_f_valid = 1'b1;
      pulse_cyc   = cyc;
      for (int i = 0; i < N; i++) begin
         exp_q.push_back('{sel, 2'(i), coefs[8*i +: 8]});
      end
      @(negedge clk);
      gen_f_valid = 1'b0;
      check("gen_ena_drop", {31'd0, gen_ena}, 0);
      check("first_wr_en", {31'd0, wr_en}, 1);
      check("first_wr_addr", {30'd0, wr_addr}, 0);
   endtask

   task automatic wait_done(output int dc);
      int t;
      t = 0;
      while (done !== 1'b1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      dc = cyc;
      check("done_seen", {31'd0, done}, 1);
   endtask

   task automatic clean_run();
      int d0, s, rf, pf, rg, pg, dc;
      d0 = dones;
      start_pulse(s);
      gen_run(1'b0, F1, 2, rf, pf);
      check("f_rise_cyc", rf, s + 1);
      gen_run(1'b1, G1, 1, rg, pg);
      check("g_rise_cyc", rg, pf + N + 1);
      wait_done(dc);
      check("done_cyc", dc, pg + N + 2);
      check("busy_at_done", {31'd0, busy}, 0);
      check("attempts_clean", {16'd0, attempts}, 0);
      @(negedge clk);
      check("done_one_cycle", {31'd0, done}, 0);
      check("clean_dones", dones - d0, 1);
      check("clean_queue_empty", exp_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200us");
      $fatal(1);
   end

   initial begin
      int d0, s, rf, pf, rg, pg, dc, t, prev;
      rst_n = 1'b1; rst_n_s = 1'b1; start = 1'b0; start_s = 1'b0;
      gen_f_valid = 1'b0; gen_f = '0;
      #2;
      rst_n = 1'b0; rst_n_s = 1'b0;
      #1;
      check_reset_outputs("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1; rst_n_s = 1'b1;
      @(negedge clk);

      // gen_f_valid in IDLE must do nothing
      gen_f = F1; gen_f_valid = 1'b1;
      @(negedge clk);
      gen_f_valid = 1'b0;
      check("idle_valid_ignored", {30'd0, busy, wr_en}, 0);

      // Accepted pair on the first attempt (norm 17)
      clean_run();

      // First f exceeds the bound (32513), second attempt accepted
      d0 = dones;
      start_pulse(s);
      gen_run(1'b0, FBIG, 1, rf, pf);
      gen_run(1'b1, G1, 1, rg, pg);
      gen_run(1'b0, F1, 1, rf, pf);
      check("retry_rise_cyc", rf, pg + N + 2);
      check("attempts_retry", {16'd0, attempts}, 1);
      check("busy_retry", {31'd0, busy}, 1);
      gen_run(1'b1, G1, 2, rg, pg);
      wait_done(dc);
      check("retry_done_cyc", dc, pg + N + 2);
      check("attempts_after_retry", {16'd0, attempts}, 1);
      @(negedge clk);
      check("retry_dones", dones - d0, 1);
      check("retry_queue_empty", exp_q.size(), 0);

      // start pulsed during COPY_F is ignored; start also clears attempts
      d0 = dones;
      start_pulse(s);
      check("attempts_cleared", {16'd0, attempts}, 0);
      gen_run(1'b0, F1, 1, rf, pf);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      gen_run(1'b1, G1, 1, rg, pg);
      check("ign_g_rise_cyc", rg, pf + N + 1);
      wait_done(dc);
      repeat (10) @(negedge clk);
      check("ign_idle_busy", {30'd0, busy, gen_ena}, 0);
      check("ign_dones", dones - d0, 1);
      check("ign_queue_empty", exp_q.size(), 0);

      // Reset on the third write of COPY_G
      d0 = dones;
      start_pulse(s);
      gen_run(1'b0, F1, 1, rf, pf);
      gen_run(1'b1, G1, 1, rg, pg);
      repeat (2) @(negedge clk);
      check("third_g_write", {29'd0, wr_en, wr_sel, wr_addr == 2'd2}, 32'h7);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrun_reset");
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("midrun_no_done", dones - d0, 0);
      clean_run();

      // Saturation: count a few rejections, preload near the top, then keep rejecting
      start_s = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
      t = 0;
      while (attempts_s < 16'd3 && t < 500) begin
         @(negedge clk);
         t++;
      end
      check("sat_count3", {16'd0, attempts_s}, 3);
      force dut_s.attempts_q = 16'hFFFC;
      @(negedge clk);
      release dut_s.attempts_q;
      prev = int'(attempts_s);
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         check("sat_no_wrap", {31'd0, int'(attempts_s) >= prev}, 1);
         prev = int'(attempts_s);
      end
      check("sat_value", {16'd0, attempts_s}, 32'hFFFF);
      check("sat_busy", {31'd0, busy_s}, 1);
      check("sat_no_done", dones_s, 0);
      rst_n_s = 1'b0;
      #1;
      check("sat_reset", {16'd0, attempts_s}, 0);
      check("sat_reset_outs",
            {19'd0, busy_s, gen_ena_s, wr_en_s, wr_sel_s, done_s, wr_addr_s, wr_data_s}, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
